universal_shreg_n: RTL and testbench

Parametrised universal shift register, the successor to the 4-bit ENB/DIR/MODO shift register. It generalises the width and keeps the hold, shift, rotate and parallel-load modes. It adds an autonomous burst-serialiser mode: the block loads a word and shifts it out bit by bit with a counter and a completion pulse. It sits between parallel datapath logic and single-wire serial links, and is exercised by the same tester/testbench pairing as the other register blocks.

---
 rtl/universal_shreg_n.sv | 117 +++++++++++
 tb/tb_universal_shreg_n.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/universal_shreg_n.sv
// ============================================================================
// Module   : universal_shreg_n
// Purpose  : Parametrised universal shift register (hold, shift, rotate,
//            parallel load) with an autonomous burst-serialiser mode.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module universal_shreg_n #(
    parameter  int WIDTH = 8,
    localparam int CW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             RST,
    input  logic             ENB,
    input  logic             DIR,
    input  logic             S_IN,
    input  logic [1:0]       MODO,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic             S_OUT,
    output logic             BUSY,
    output logic             DONE,
    output logic [CW-1:0]    CNT
);

    localparam logic [0:0] c_IDLE  = 1'b0;
    localparam logic [0:0] c_BURST = 1'b1;

    localparam logic [1:0] c_MODE_SHIFT  = 2'b00;
    localparam logic [1:0] c_MODE_ROTATE = 2'b01;
    localparam logic [1:0] c_MODE_LOAD   = 2'b10;
    localparam logic [1:0] c_MODE_BURST  = 2'b11;

    logic [0:0]       r_state;
    logic [WIDTH-1:0] r_q;
    logic             r_sout;
    logic             r_done;
    logic [CW-1:0]    r_cnt;
    logic             r_bdir;

    logic [WIDTH-1:0] w_shl;
    logic [WIDTH-1:0] w_shr;
    logic [WIDTH-1:0] w_rotl;
    logic [WIDTH-1:0] w_rotr;
    logic [WIDTH-1:0] w_burst_q;
    logic             w_burst_out;

    assign w_shl  = {r_q[WIDTH-2:0], S_IN};
    assign w_shr  = {S_IN, r_q[WIDTH-1:1]};
    assign w_rotl = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
    assign w_rotr = {r_q[0], r_q[WIDTH-1:1]};

    // A burst follows the direction captured at its start, not the live DIR.
    assign w_burst_q   = r_bdir ? w_shl : w_shr;
    assign w_burst_out = r_bdir ? r_q[WIDTH-1] : r_q[0];

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            r_state <= c_IDLE;
            r_q     <= '0;
            r_sout  <= 1'b0;
            r_done  <= 1'b0;
            r_cnt   <= '0;
            r_bdir  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (ENB) begin
                        case (MODO)
                            c_MODE_SHIFT: begin
                                r_q    <= DIR ? w_shl : w_shr;
                                r_sout <= DIR ? r_q[WIDTH-1] : r_q[0];
                            end
                            c_MODE_ROTATE: begin
                                r_q    <= DIR ? w_rotl : w_rotr;
                                r_sout <= DIR ? r_q[WIDTH-1] : r_q[0];
                            end
                            c_MODE_LOAD: begin
                                r_q <= D;
                            end
                            c_MODE_BURST: begin
                                r_q     <= D;
                                r_cnt   <= CW'(WIDTH);
                                r_bdir  <= DIR;
                                r_state <= c_BURST;
                            end
                            default: ;
                        endcase
                    end
                end
                c_BURST: begin
                    r_q    <= w_burst_q;
                    r_sout <= w_burst_out;
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                    if (r_cnt <= CW'(1)) begin
                        r_state <= c_IDLE;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign Q     = r_q;
    assign S_OUT = r_sout;
    assign BUSY  = (r_state == c_BURST);
    assign DONE  = r_done;
    assign CNT   = r_cnt;

endmodule

`default_nettype wire

// File: tb/tb_universal_shreg_n.sv
// ============================================================================
// Module   : tb_universal_shreg_n
// Purpose  : Self-checking bench for universal_shreg_n (WIDTH=8 and WIDTH=4).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_universal_shreg_n;

    typedef struct {
        logic       enb;
        logic       dir;
        logic       s_in;
        logic [1:0] modo;
        logic [7:0] d;
        logic       sel4;
        logic [7:0] q;
        logic       sout;
        logic       busy;
        logic       done;
        logic [3:0] cnt;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enb = 1'b0;
    logic       dir = 1'b0;
    logic       s_in = 1'b0;
    logic [1:0] modo = 2'b00;
    logic [7:0] d = 8'h00;

    logic [7:0] q8;
    logic       sout8, busy8, done8;
    logic [3:0] cnt8;
    logic [3:0] q4;
    logic       sout4, busy4, done4;
    logic [2:0] cnt4;

    int n_checks = 0;
    int n_errors = 0;

    vec_t tbl[$];
    vec_t sb[$];

    always #5 clk = ~clk;

    universal_shreg_n #(.WIDTH(8)) dut8 (
        .clk(clk), .RST(rst), .ENB(enb), .DIR(dir), .S_IN(s_in), .MODO(modo),
        .D(d), .Q(q8), .S_OUT(sout8), .BUSY(busy8), .DONE(done8), .CNT(cnt8)
    );

    universal_shreg_n #(.WIDTH(4)) dut4 (
        .clk(clk), .RST(rst), .ENB(enb), .DIR(dir), .S_IN(s_in), .MODO(modo),
        .D(d[3:0]), .Q(q4), .S_OUT(sout4), .BUSY(busy4), .DONE(done4), .CNT(cnt4)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic e, input logic di, input logic si,
                                input logic [1:0] m, input logic [7:0] dd, input logic s4,
                                input logic [7:0] eq, input logic es, input logic eb,
                                input logic ed, input logic [3:0] ec);
        vec_t v;
        v.enb = e; v.dir = di; v.s_in = si; v.modo = m; v.d = dd; v.sel4 = s4;
        v.q = eq; v.sout = es; v.busy = eb; v.done = ed; v.cnt = ec;
        return v;
    endfunction

    task automatic compare(input vec_t e, input string tag);
        if (e.sel4) begin
            check({tag, ".q"},    {28'd0, q4},   {24'd0, e.q});
            check({tag, ".sout"}, {31'd0, sout4}, {31'd0, e.sout});
            check({tag, ".busy"}, {31'd0, busy4}, {31'd0, e.busy});
            check({tag, ".done"}, {31'd0, done4}, {31'd0, e.done});
            check({tag, ".cnt"},  {29'd0, cnt4},  {28'd0, e.cnt});
        end else begin
            check({tag, ".q"},    {24'd0, q8},   {24'd0, e.q});
            check({tag, ".sout"}, {31'd0, sout8}, {31'd0, e.sout});
            check({tag, ".busy"}, {31'd0, busy8}, {31'd0, e.busy});
            check({tag, ".done"}, {31'd0, done8}, {31'd0, e.done});
            check({tag, ".cnt"},  {28'd0, cnt8},  {28'd0, e.cnt});
        end
    endtask

    // Drive one record between edges, queue its expectation, compare after the edge.
    task automatic apply(input vec_t v, input string tag);
        vec_t e;
        @(negedge clk);
        enb = v.enb; dir = v.dir; s_in = v.s_in; modo = v.modo; d = v.d;
        sb.push_back(v);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        compare(e, tag);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; enb = 1'b0; modo = 2'b00; dir = 1'b0; s_in = 1'b0; d = 8'h00;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        //            enb dir sin modo   d      s4  q      so  bsy dn  cnt
        tbl.push_back(mk(1, 0, 0, 2'b10, 8'hA5, 0, 8'hA5, 0, 0, 0, 4'd0)); // load
        tbl.push_back(mk(0, 1, 1, 2'b00, 8'hFF, 0, 8'hA5, 0, 0, 0, 4'd0)); // hold x3
        tbl.push_back(mk(0, 0, 1, 2'b01, 8'h3C, 0, 8'hA5, 0, 0, 0, 4'd0));
        tbl.push_back(mk(0, 1, 0, 2'b11, 8'h00, 0, 8'hA5, 0, 0, 0, 4'd0));
        tbl.push_back(mk(1, 1, 1, 2'b00, 8'h00, 0, 8'h4B, 1, 0, 0, 4'd0)); // shl fill 1
        tbl.push_back(mk(1, 0, 0, 2'b10, 8'hA5, 0, 8'hA5, 1, 0, 0, 4'd0));
        tbl.push_back(mk(1, 0, 0, 2'b00, 8'h00, 0, 8'h52, 1, 0, 0, 4'd0)); // shr fill 0
        tbl.push_back(mk(1, 0, 0, 2'b10, 8'hA5, 0, 8'hA5, 1, 0, 0, 4'd0));
        tbl.push_back(mk(1, 0, 1, 2'b01, 8'h00, 0, 8'hD2, 1, 0, 0, 4'd0)); // rotr
        tbl.push_back(mk(1, 1, 0, 2'b01, 8'h00, 0, 8'hA5, 1, 0, 0, 4'd0)); // rotl
        tbl.push_back(mk(1, 0, 0, 2'b10, 8'h7E, 0, 8'h7E, 1, 0, 0, 4'd0));
        tbl.push_back(mk(1, 1, 0, 2'b00, 8'h00, 0, 8'hFC, 0, 0, 0, 4'd0));
        tbl.push_back(mk(1, 0, 1, 2'b00, 8'h00, 0, 8'hFE, 0, 0, 0, 4'd0));
        // Burst of 0x96, LSB first; mid-burst inputs must be ignored.
        tbl.push_back(mk(1, 0, 0, 2'b11, 8'h96, 0, 8'h96, 0, 1, 0, 4'd8));
        tbl.push_back(mk(1, 1, 0, 2'b10, 8'hFF, 0, 8'h4B, 0, 1, 0, 4'd7));
        tbl.push_back(mk(1, 1, 0, 2'b11, 8'h11, 0, 8'h25, 1, 1, 0, 4'd6));
        tbl.push_back(mk(0, 0, 0, 2'b01, 8'h00, 0, 8'h12, 1, 1, 0, 4'd5));
        tbl.push_back(mk(1, 0, 0, 2'b00, 8'h00, 0, 8'h09, 0, 1, 0, 4'd4));
        tbl.push_back(mk(1, 1, 0, 2'b10, 8'hAA, 0, 8'h04, 1, 1, 0, 4'd3));
        tbl.push_back(mk(0, 0, 0, 2'b11, 8'h00, 0, 8'h02, 0, 1, 0, 4'd2));
        tbl.push_back(mk(1, 0, 0, 2'b01, 8'h00, 0, 8'h01, 0, 1, 0, 4'd1));
        tbl.push_back(mk(0, 0, 0, 2'b00, 8'h00, 0, 8'h00, 1, 0, 1, 4'd0));
        tbl.push_back(mk(0, 0, 0, 2'b00, 8'h00, 0, 8'h00, 1, 0, 0, 4'd0));

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        compare(mk(0, 0, 0, 2'b00, 8'h00, 0, 8'h00, 0, 0, 0, 4'd0), "reset8");
        compare(mk(0, 0, 0, 2'b00, 8'h00, 1, 8'h00, 0, 0, 0, 4'd0), "reset4");
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i], $sformatf("vec%0d", i));
        end

        // Asynchronous reset at the 4th shift of a burst
        apply(mk(1, 0, 0, 2'b11, 8'h96, 0, 8'h96, 1, 1, 0, 4'd8), "arst.e0");
        apply(mk(0, 0, 0, 2'b00, 8'h00, 0, 8'h4B, 0, 1, 0, 4'd7), "arst.e1");
        apply(mk(0, 0, 0, 2'b00, 8'h00, 0, 8'h25, 1, 1, 0, 4'd6), "arst.e2");
        apply(mk(0, 0, 0, 2'b00, 8'h00, 0, 8'h12, 1, 1, 0, 4'd5), "arst.e3");
        apply(mk(0, 0, 0, 2'b00, 8'h00, 0, 8'h09, 0, 1, 0, 4'd4), "arst.e4");
        #1;
        rst = 1'b1;
        #1;
        compare(mk(0, 0, 0, 2'b00, 8'h00, 0, 8'h00, 0, 0, 0, 4'd0), "arst.async");
        @(negedge clk);
        rst = 1'b0;
        apply(mk(0, 0, 0, 2'b00, 8'h00, 0, 8'h00, 0, 0, 0, 4'd0), "arst.idle");

        // Back-to-back bursts on the 4-bit instance, MODO=11 held
        do_reset();
        apply(mk(1, 0, 0, 2'b11, 8'h09, 1, 8'h09, 0, 1, 0, 4'd4), "b2b.e0");
        apply(mk(1, 0, 0, 2'b11, 8'h09, 1, 8'h04, 1, 1, 0, 4'd3), "b2b.e1");
        apply(mk(1, 0, 0, 2'b11, 8'h09, 1, 8'h02, 0, 1, 0, 4'd2), "b2b.e2");
        apply(mk(1, 0, 0, 2'b11, 8'h09, 1, 8'h01, 0, 1, 0, 4'd1), "b2b.e3");
        apply(mk(1, 0, 0, 2'b11, 8'h09, 1, 8'h00, 1, 0, 1, 4'd0), "b2b.e4");
        apply(mk(1, 0, 0, 2'b11, 8'h06, 1, 8'h06, 1, 1, 0, 4'd4), "b2b.e5");
        apply(mk(1, 0, 0, 2'b11, 8'h06, 1, 8'h03, 0, 1, 0, 4'd3), "b2b.e6");
        apply(mk(1, 0, 0, 2'b11, 8'h06, 1, 8'h01, 1, 1, 0, 4'd2), "b2b.e7");
        apply(mk(1, 0, 0, 2'b11, 8'h06, 1, 8'h00, 1, 1, 0, 4'd1), "b2b.e8");
        apply(mk(1, 0, 0, 2'b11, 8'h06, 1, 8'h00, 0, 0, 1, 4'd0), "b2b.e9");
        apply(mk(0, 0, 0, 2'b11, 8'h06, 1, 8'h00, 0, 0, 0, 4'd0), "b2b.e10");

        // MSB-first burst on the 4-bit instance with a filling S_IN
        apply(mk(1, 1, 1, 2'b11, 8'h0A, 1, 8'h0A, 0, 1, 0, 4'd4), "msb.e0");
        apply(mk(0, 0, 1, 2'b00, 8'h00, 1, 8'h05, 1, 1, 0, 4'd3), "msb.e1");
        apply(mk(0, 0, 1, 2'b00, 8'h00, 1, 8'h0B, 0, 1, 0, 4'd2), "msb.e2");
        apply(mk(0, 0, 1, 2'b00, 8'h00, 1, 8'h07, 1, 1, 0, 4'd1), "msb.e3");
        apply(mk(0, 0, 1, 2'b00, 8'h00, 1, 8'h0F, 0, 0, 1, 4'd0), "msb.e4");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
